// File: rtl/frame_recover.sv
// Pixel-stream recovery: qualifies pixel strobes, tags each pixel with its raster
// coordinate and frame markers, and enforces the configured frame geometry.
module frame_recover #(
  parameter int WIDTH            = 640,
  parameter int HEIGHT           = 480,
  parameter int PIXEL_BITS       = 16,
  parameter int EDGE_MODE        = 1,
  parameter int FRAME_COUNT_BITS = 8,
  localparam int HW = $clog2(WIDTH),
  localparam int VW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                        system_clk_in,
  input  logic                        rst_in,
  input  logic                        valid_pixel_in,
  input  logic [PIXEL_BITS-1:0]       pixel_in,
  input  logic                        frame_done_in,
  output logic [PIXEL_BITS-1:0]       pixel_out,
  output logic                        data_valid_out,
  output logic [HW-1:0]               hcount_out,
  output logic [VW-1:0]               vcount_out,
  output logic                        sof_out,
  output logic                        eol_out,
  output logic                        eof_out,
  output logic                        overrun_out,
  output logic                        short_frame_out,
  output logic [FRAME_COUNT_BITS-1:0] frame_count_out
);

  // state    | meaning
  // WAIT_SOF | idle, next accepted pixel starts a frame at (0,0)
  // ACTIVE   | frame in progress, pixels emitted at (h,v)
  // FULL     | frame complete, further pixels dropped as overrun
  typedef enum logic [1:0] {WAIT_SOF, ACTIVE, FULL} state_t;

  localparam logic [HW-1:0] H_LAST = HW'(WIDTH - 1);
  localparam logic [VW-1:0] V_LAST = VW'(HEIGHT - 1);

  state_t                      state_q, state_d;
  logic                        prev_q;
  logic [HW-1:0]               h_q, h_d;
  logic [VW-1:0]               v_q, v_d;
  logic [FRAME_COUNT_BITS-1:0] fc_q, fc_d;
  logic [PIXEL_BITS-1:0]       pix_q, pix_d;
  logic [HW-1:0]               hc_q, hc_d;
  logic [VW-1:0]               vc_q, vc_d;
  logic                        dv_q, dv_d;
  logic                        sof_q, sof_d;
  logic                        eol_q, eol_d;
  logic                        eof_q, eof_d;
  logic                        ovr_q, ovr_d;
  logic                        short_q, short_d;
  logic                        accept;

  always_ff @(posedge system_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= WAIT_SOF;
      prev_q  <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      fc_q    <= '0;
      pix_q   <= '0;
      hc_q    <= '0;
      vc_q    <= '0;
      dv_q    <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      ovr_q   <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= valid_pixel_in;
      h_q     <= h_d;
      v_q     <= v_d;
      fc_q    <= fc_d;
      pix_q   <= pix_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      dv_q    <= dv_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      ovr_q   <= ovr_d;
      short_q <= short_d;
    end
  end

  always_comb begin
    if (EDGE_MODE != 0) accept = valid_pixel_in & ~prev_q;
    else                accept = valid_pixel_in;
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    fc_d    = fc_q;
    pix_d   = pix_q;
    hc_d    = hc_q;
    vc_d    = vc_q;
    dv_d    = 1'b0;
    sof_d   = 1'b0;
    eol_d   = 1'b0;
    eof_d   = 1'b0;
    ovr_d   = 1'b0;
    short_d = 1'b0;

    // End-of-frame from the capture path wins over a same-cycle accept
    if (frame_done_in) begin
      short_d = (state_q == ACTIVE);
      h_d     = '0;
      v_d     = '0;
      state_d = WAIT_SOF;
    end else if (accept) begin
      case (state_q)
        WAIT_SOF: begin
          dv_d    = 1'b1;
          sof_d   = 1'b1;
          pix_d   = pixel_in;
          hc_d    = '0;
          vc_d    = '0;
          h_d     = HW'(1);
          v_d     = '0;
          state_d = ACTIVE;
        end
        ACTIVE: begin
          dv_d  = 1'b1;
          pix_d = pixel_in;
          hc_d  = h_q;
          vc_d  = v_q;
          h_d   = h_q + 1'b1;
          if (h_q == H_LAST) begin
            eol_d = 1'b1;
            h_d   = '0;
            v_d   = v_q + 1'b1;
            if (v_q == V_LAST) begin
              eof_d   = 1'b1;
              v_d     = '0;
              fc_d    = fc_q + 1'b1;
              state_d = FULL;
            end
          end
        end
        FULL: begin
          ovr_d = 1'b1;
        end
        default: state_d = WAIT_SOF;
      endcase
    end
  end

  assign pixel_out       = pix_q;
  assign data_valid_out  = dv_q;
  assign hcount_out      = hc_q;
  assign vcount_out      = vc_q;
  assign sof_out         = sof_q;
  assign eol_out         = eol_q;
  assign eof_out         = eof_q;
  assign overrun_out     = ovr_q;
  assign short_frame_out = short_q;
  assign frame_count_out = fc_q;

endmodule
